store_buffer: RTL and testbench

Memory-stage store path of the RV32I pipeline. It turns sb/sh/sw requests into byte-lane-aligned write data plus a 4-bit byte strobe, and queues them in a DEPTH-entry FIFO. It drains the FIFO to data memory over a valid/ready write port. It also flags load-after-store hazards against pending entries so the hazard unit can stall the pipeline. It is the write-side counterpart of the load extension logic.

---
 rtl/store_buffer.sv | 130 +++++++++++++
 tb/tb_store_buffer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: formats sb/sh/sw stores into lane-aligned data and byte strobes,
// queues them in a DEPTH-entry FIFO, drains them over a valid/ready write port,
// and flags loads that hit a pending store word.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     StoreM,
  input  logic                     LoadM,
  input  logic [2:0]               StoreTypeM,
  input  logic [31:0]              AddrM,
  input  logic [31:0]              WriteDataM,
  output logic                     StallM,
  output logic                     MisalignM,
  output logic                     Empty,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     mem_valid,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_wstrb,
  input  logic                     mem_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [29:0]    addr_q  [DEPTH];
  logic [31:0]    wdata_q [DEPTH];
  logic [3:0]     wstrb_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;

  logic [31:0]    fmt_wdata;
  logic [3:0]     fmt_wstrb;
  logic           bad_store;
  logic           full, enq, deq, load_hit;

  // Lane replication, byte strobes and alignment/funct3 legality.
  always_comb begin
    fmt_wdata = WriteDataM;
    fmt_wstrb = 4'b0000;
    bad_store = 1'b0;
    case (StoreTypeM)
      3'b000: begin
        fmt_wdata = {4{WriteDataM[7:0]}};
        fmt_wstrb = 4'b0001 << AddrM[1:0];
      end
      3'b001: begin
        fmt_wdata = {2{WriteDataM[15:0]}};
        fmt_wstrb = AddrM[1] ? 4'b1100 : 4'b0011;
        bad_store = AddrM[0];
      end
      3'b010: begin
        fmt_wdata = WriteDataM;
        fmt_wstrb = 4'b1111;
        bad_store = |AddrM[1:0];
      end
      default: bad_store = 1'b1;
    endcase
  end

  // Load hazard: any valid entry in the same word, including the one draining now.
  always_comb begin
    load_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == AddrM[31:2])) load_hit = 1'b1;
    end
  end

  assign full      = (count_q == CW'(DEPTH));
  assign Empty     = (count_q == '0);
  assign Count     = count_q;
  assign MisalignM = StoreM & bad_store;
  assign enq       = StoreM & ~bad_store & ~full;
  assign deq       = mem_valid & mem_ready;
  assign StallM    = (StoreM & ~bad_store & full) | (LoadM & ~StoreM & load_hit);

  assign mem_valid = ~Empty;
  assign mem_addr  = Empty ? 32'h0 : {addr_q[head_q], 2'b00};
  assign mem_wdata = Empty ? 32'h0 : wdata_q[head_q];
  assign mem_wstrb = Empty ? 4'h0  : wstrb_q[head_q];

  // Next-state for pointers, occupancy and per-entry valid bits.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (deq) begin
      head_d          = head_q + AW'(1);
      valid_d[head_q] = 1'b0;
    end
    if (enq) begin
      tail_d          = tail_q + AW'(1);
      valid_d[tail_q] = 1'b1;
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards everything pending, including an in-flight handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Entry payload; only meaningful while its valid bit is set, so no reset needed.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q]  <= AddrM[31:2];
      wdata_q[tail_q] <= fmt_wdata;
      wstrb_q[tail_q] <= fmt_wstrb;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed table-driven bench for store_buffer plus a back-to-back drain sequence.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset, StoreM, LoadM, mem_ready;
  logic [2:0]  StoreTypeM;
  logic [31:0] AddrM, WriteDataM;
  logic        StallM, MisalignM, Empty, mem_valid;
  logic [2:0]  Count;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .StoreM(StoreM), .LoadM(LoadM),
    .StoreTypeM(StoreTypeM), .AddrM(AddrM), .WriteDataM(WriteDataM),
    .StallM(StallM), .MisalignM(MisalignM), .Empty(Empty), .Count(Count),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, st, ld;
    logic [2:0]  ty;
    logic [31:0] a, wd;
    logic        rdy;
    logic        e_stall, e_mis, e_empty;
    logic [2:0]  e_cnt;
    logic        e_val;
    logic [31:0] e_ma, e_wd;
    logic [3:0]  e_ws;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010, BAD = 3'b100;

  task automatic v(input logic rst, st, ld, input logic [2:0] ty, input logic [31:0] a, wd,
                   input logic rdy, e_stall, e_mis, e_empty, input logic [2:0] e_cnt,
                   input logic e_val, input logic [31:0] e_ma, e_wd, input logic [3:0] e_ws);
    vec_t t;
    t.rst = rst; t.st = st; t.ld = ld; t.ty = ty; t.a = a; t.wd = wd; t.rdy = rdy;
    t.e_stall = e_stall; t.e_mis = e_mis; t.e_empty = e_empty; t.e_cnt = e_cnt;
    t.e_val = e_val; t.e_ma = e_ma; t.e_wd = e_wd; t.e_ws = e_ws;
    vecs.push_back(t);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got 0x%08h want 0x%08h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, st, ld, input logic [2:0] ty,
                       input logic [31:0] a, wd, input logic rdy);
    reset = rst; StoreM = st; LoadM = ld; StoreTypeM = ty;
    AddrM = a; WriteDataM = wd; mem_ready = rdy;
  endtask

  logic [31:0] hs_addr [5];
  logic [31:0] hs_data [5];
  logic [2:0]  hs_ty   [5];
  logic        hs_st   [5];
  logic        hs_eval [5];
  logic [31:0] hs_ema  [5];
  logic [31:0] hs_ewd  [5];
  logic [3:0]  hs_ews  [5];

  initial begin
    //  rst st ld ty   addr          wdata         rdy stall mis emp cnt val mem_addr      mem_wdata     wstrb
    v(0, 0, 0, SW,  32'h0,        32'h0,        1,  0, 0, 1, 3'd0, 0, 32'h0,        32'h0,        4'h0);
    v(0, 1, 0, SB,  32'h10000003, 32'h000000A5, 1,  0, 0, 1, 3'd0, 0, 32'h0,        32'h0,        4'h0);
    v(0, 0, 0, SW,  32'h0,        32'h0,        1,  0, 0, 0, 3'd1, 1, 32'h10000000, 32'hA5A5A5A5, 4'b1000);
    v(0, 0, 0, SW,  32'h0,        32'h0,        0,  0, 0, 1, 3'd0, 0, 32'h0,        32'h0,        4'h0);
    v(0, 1, 0, SH,  32'h00000102, 32'h1234BEEF, 0,  0, 0, 1, 3'd0, 0, 32'h0,        32'h0,        4'h0);
    v(0, 1, 0, SH,  32'h00000101, 32'h1234BEEF, 0,  0, 1, 0, 3'd1, 1, 32'h00000100, 32'hBEEFBEEF, 4'b1100);
    v(0, 0, 0, SW,  32'h0,        32'h0,        1,  0, 0, 0, 3'd1, 1, 32'h00000100, 32'hBEEFBEEF, 4'b1100);
    v(0, 0, 0, SW,  32'h0,        32'h0,        0,  0, 0, 1, 3'd0, 0, 32'h0,        32'h0,        4'h0);
    v(0, 1, 0, SW,  32'h10,       32'h11111111, 0,  0, 0, 1, 3'd0, 0, 32'h0,        32'h0,        4'h0);
    v(0, 1, 0, SW,  32'h14,       32'h22222222, 0,  0, 0, 0, 3'd1, 1, 32'h10,       32'h11111111, 4'hF);
    v(0, 1, 0, SW,  32'h18,       32'h33333333, 0,  0, 0, 0, 3'd2, 1, 32'h10,       32'h11111111, 4'hF);
    v(0, 1, 0, SW,  32'h1C,       32'h44444444, 0,  0, 0, 0, 3'd3, 1, 32'h10,       32'h11111111, 4'hF);
    v(0, 1, 0, SW,  32'h20,       32'h55555555, 0,  1, 0, 0, 3'd4, 1, 32'h10,       32'h11111111, 4'hF);
    v(0, 1, 0, SW,  32'h20,       32'h55555555, 1,  1, 0, 0, 3'd4, 1, 32'h10,       32'h11111111, 4'hF);
    v(0, 0, 0, SW,  32'h0,        32'h0,        1,  0, 0, 0, 3'd3, 1, 32'h14,       32'h22222222, 4'hF);
    v(0, 1, 0, SW,  32'h24,       32'h66666666, 1,  0, 0, 0, 3'd2, 1, 32'h18,       32'h33333333, 4'hF);
    v(0, 0, 0, SW,  32'h0,        32'h0,        1,  0, 0, 0, 3'd2, 1, 32'h1C,       32'h44444444, 4'hF);
    v(0, 0, 0, SW,  32'h0,        32'h0,        1,  0, 0, 0, 3'd1, 1, 32'h24,       32'h66666666, 4'hF);
    v(0, 0, 0, SW,  32'h0,        32'h0,        0,  0, 0, 1, 3'd0, 0, 32'h0,        32'h0,        4'h0);
    v(0, 1, 0, SW,  32'h2000,     32'hCAFEF00D, 0,  0, 0, 1, 3'd0, 0, 32'h0,        32'h0,        4'h0);
    v(0, 0, 1, SW,  32'h2002,     32'h0,        0,  1, 0, 0, 3'd1, 1, 32'h2000,     32'hCAFEF00D, 4'hF);
    v(0, 0, 1, SW,  32'h2004,     32'h0,        0,  0, 0, 0, 3'd1, 1, 32'h2000,     32'hCAFEF00D, 4'hF);
    v(0, 1, 1, SW,  32'h2000,     32'h77777777, 0,  0, 0, 0, 3'd1, 1, 32'h2000,     32'hCAFEF00D, 4'hF);
    v(0, 0, 1, SW,  32'h2002,     32'h0,        1,  1, 0, 0, 3'd2, 1, 32'h2000,     32'hCAFEF00D, 4'hF);
    v(0, 0, 1, SW,  32'h2002,     32'h0,        1,  1, 0, 0, 3'd1, 1, 32'h2000,     32'h77777777, 4'hF);
    v(0, 0, 1, SW,  32'h2002,     32'h0,        0,  0, 0, 1, 3'd0, 0, 32'h0,        32'h0,        4'h0);
    v(0, 1, 0, BAD, 32'h30,       32'h12345678, 0,  0, 1, 1, 3'd0, 0, 32'h0,        32'h0,        4'h0);
    v(0, 0, 0, SW,  32'h0,        32'h0,        0,  0, 0, 1, 3'd0, 0, 32'h0,        32'h0,        4'h0);
    v(0, 1, 0, SH,  32'h40,       32'hAAAA5678, 0,  0, 0, 1, 3'd0, 0, 32'h0,        32'h0,        4'h0);
    v(0, 1, 0, SB,  32'h41,       32'h0000003C, 0,  0, 0, 0, 3'd1, 1, 32'h40,       32'h56785678, 4'b0011);
    v(0, 1, 0, SW,  32'h48,       32'h99999999, 0,  0, 0, 0, 3'd2, 1, 32'h40,       32'h56785678, 4'b0011);
    v(1, 0, 0, SW,  32'h0,        32'h0,        1,  0, 0, 0, 3'd3, 1, 32'h40,       32'h56785678, 4'b0011);
    v(0, 0, 0, SW,  32'h0,        32'h0,        0,  0, 0, 1, 3'd0, 0, 32'h0,        32'h0,        4'h0);
    v(0, 1, 0, SW,  32'h50,       32'h12345678, 0,  0, 0, 1, 3'd0, 0, 32'h0,        32'h0,        4'h0);
    v(0, 0, 0, SW,  32'h0,        32'h0,        1,  0, 0, 0, 3'd1, 1, 32'h50,       32'h12345678, 4'hF);
    v(0, 0, 0, SW,  32'h0,        32'h0,        0,  0, 0, 1, 3'd0, 0, 32'h0,        32'h0,        4'h0);

    // Back-to-back stores with mem_ready high: one entry per cycle, one cycle latency.
    hs_st   = '{1, 1, 1, 0, 0};
    hs_ty   = '{SB, SH, SW, SW, SW};
    hs_addr = '{32'h61, 32'h66, 32'h68, 32'h0, 32'h0};
    hs_data = '{32'h0000003C, 32'h00005678, 32'hDEADBEEF, 32'h0, 32'h0};
    hs_eval = '{0, 1, 1, 1, 0};
    hs_ema  = '{32'h0, 32'h60, 32'h64, 32'h68, 32'h0};
    hs_ewd  = '{32'h0, 32'h3C3C3C3C, 32'h56785678, 32'hDEADBEEF, 32'h0};
    hs_ews  = '{4'h0, 4'b0010, 4'b1100, 4'b1111, 4'h0};

    drive(1, 0, 0, SW, 32'h0, 32'h0, 0);
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].st, vecs[i].ld, vecs[i].ty, vecs[i].a, vecs[i].wd, vecs[i].rdy);
      #1;
      n_vec++;
      chk("StallM",    i, {31'b0, StallM},    {31'b0, vecs[i].e_stall});
      chk("MisalignM", i, {31'b0, MisalignM}, {31'b0, vecs[i].e_mis});
      chk("Empty",     i, {31'b0, Empty},     {31'b0, vecs[i].e_empty});
      chk("Count",     i, {29'b0, Count},     {29'b0, vecs[i].e_cnt});
      chk("mem_valid", i, {31'b0, mem_valid}, {31'b0, vecs[i].e_val});
      chk("mem_addr",  i, mem_addr,           vecs[i].e_ma);
      chk("mem_wdata", i, mem_wdata,          vecs[i].e_wd);
      chk("mem_wstrb", i, {28'b0, mem_wstrb}, {28'b0, vecs[i].e_ws});
    end

    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(0, hs_st[k], 0, hs_ty[k], hs_addr[k], hs_data[k], 1);
      #1;
      n_vec++;
      chk("stream_valid", 100 + k, {31'b0, mem_valid}, {31'b0, hs_eval[k]});
      chk("stream_addr",  100 + k, mem_addr,           hs_ema[k]);
      chk("stream_wdata", 100 + k, mem_wdata,          hs_ewd[k]);
      chk("stream_wstrb", 100 + k, {28'b0, mem_wstrb}, {28'b0, hs_ews[k]});
      chk("stream_stall", 100 + k, {31'b0, StallM},    32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
